// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings and widths.
package wb_stage_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_W        = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction and sign/zero extension with misalignment detection.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    output logic [XLEN-1:0] data_o,
    output logic            err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        err_o  = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
                err_o  = off_i[0];
            end
            F3_LHU: begin
                data_o = {{(XLEN-16){1'b0}}, half_sel};
                err_o  = off_i[0];
            end
            F3_LW:   err_o = (off_i != 2'b00);
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: EX/MEM arbitration with EX starvation guard, registered regfile write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned XLEN         = XLEN_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ex_valid_i,
    output logic             ex_ready_o,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic [XLEN-1:0]  ex_data_i,
    input  logic             mem_valid_i,
    output logic             mem_ready_o,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    input  logic [2:0]       mem_funct3_i,
    input  logic [1:0]       mem_off_i,
    output logic             rf_wr_en_o,
    output logic [REG_W-1:0] rf_rd_addr_o,
    output logic [XLEN-1:0]  rf_wr_data_o,
    output logic             fwd_valid_o,
    output logic [REG_W-1:0] fwd_rd_o,
    output logic [XLEN-1:0]  fwd_data_o,
    output logic             load_err_o
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]      retire_cnt_o
`endif
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    logic [3:0]       starve_q, starve_d;
    logic             wr_en_q, wr_en_d;
    logic [REG_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             err_q, err_d;
    logic             ex_gnt, mem_gnt;
    logic [XLEN-1:0]  ld_data;
    logic             ld_err;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata_i  (mem_rdata_i),
        .funct3_i (mem_funct3_i),
        .off_i    (mem_off_i),
        .data_o   (ld_data),
        .err_o    (ld_err)
    );

    // MEM wins ties until EX has lost STARVE_LIMIT times in a row.
    always_comb begin
        ex_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (rst_ni) begin
            if (ex_valid_i && (!mem_valid_i || starve_q >= StarveMax)) begin
                ex_gnt = 1'b1;
            end else if (mem_valid_i) begin
                mem_gnt = 1'b1;
            end
        end
    end

    assign ex_ready_o  = ex_gnt;
    assign mem_ready_o = mem_gnt;

    always_comb begin
        starve_d = 4'd0;
        if (ex_valid_i && !ex_gnt) begin
            starve_d = (starve_q >= StarveMax) ? StarveMax : starve_q + 4'd1;
        end
    end

    // rd==0 and faulting loads still consume the slot but never write.
    always_comb begin
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;
        if (ex_gnt) begin
            wr_en_d = (ex_rd_i != '0);
            addr_d  = ex_rd_i;
            data_d  = ex_data_i;
        end else if (mem_gnt) begin
            err_d = ld_err;
            if (!ld_err) begin
                wr_en_d = (mem_rd_i != '0);
                addr_d  = mem_rd_i;
                data_d  = ld_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_q <= 4'd0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign rf_wr_en_o   = wr_en_q;
    assign rf_rd_addr_o = addr_q;
    assign rf_wr_data_o = data_q;
    assign fwd_valid_o  = wr_en_q;
    assign fwd_rd_o     = addr_q;
    assign fwd_data_o   = data_q;
    assign load_err_o   = err_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            retire_q <= 64'd0;
        end else if (ex_gnt || mem_gnt) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign retire_cnt_o = retire_q;
`endif

endmodule
